// File: rtl/moddiv_pkg.sv
// Shared constants and state encoding for the moddiv operand path.
package moddiv_pkg;

    localparam int WORD_W  = 16;
    localparam int NWORDS  = 16;
    localparam int TOTAL_W = WORD_W * NWORDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UNLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_slice_16.sv
// One 16-bit word of the operand register: shifts left by one bit while
// collecting, or loads the next-higher word while unloading.
module sipo_slice_16
    import moddiv_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              i_shift_en,
    input  logic              i_load_en,
    input  logic              i_ser,
    input  logic [WORD_W-1:0] i_par,
    output logic [WORD_W-1:0] o_q
);

    logic [WORD_W-1:0] r_q;

    // Shift and load are never requested together: they belong to different states.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {r_q[WORD_W-2:0], i_ser};
        end else if (i_load_en) begin
            r_q <= i_par;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sipo_shi_reg_256.sv
// 256-bit serial-in, word-parallel-out operand register: collects bits MSB
// first, then unloads 16-bit words least-significant first under valid/ready.
module sipo_shi_reg_256
    import moddiv_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_vld,
    output logic              bit_rdy,
    output logic [WORD_W-1:0] word_out,
    output logic              word_vld,
    input  logic              word_rdy,
    output logic              busy,
    output logic              done
);

    localparam int BCNT_W = $clog2(TOTAL_W);
    localparam int WCNT_W = $clog2(NWORDS);

    state_t              r_state;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic                r_bit_rdy;
    logic                r_word_vld;
    logic                r_busy;
    logic                r_done;

    logic                w_shift_en;
    logic                w_load_en;
    logic [WORD_W-1:0]   w_q   [NWORDS];
    logic                w_ser [NWORDS];
    logic [WORD_W-1:0]   w_par [NWORDS];

    assign w_shift_en = r_bit_rdy && bit_vld;
    assign w_load_en  = r_word_vld && word_rdy;

    // Slice k holds data[16k+15:16k]; bits ripple upward on shift, words move down on load.
    for (genvar k = 0; k < NWORDS; k++) begin : g_slice
        if (k == 0) begin : g_lo
            assign w_ser[k] = bit_in;
        end else begin : g_mid
            assign w_ser[k] = w_q[k-1][WORD_W-1];
        end
        if (k == NWORDS - 1) begin : g_hi
            assign w_par[k] = '0;
        end else begin : g_below
            assign w_par[k] = w_q[k+1];
        end

        sipo_slice_16 u_slice (
            .clk        (clk),
            .clr_n      (clr_n),
            .i_shift_en (w_shift_en),
            .i_load_en  (w_load_en),
            .i_ser      (w_ser[k]),
            .i_par      (w_par[k]),
            .o_q        (w_q[k])
        );
    end

    // Outputs are registered next to the state so they change only on state transitions.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_bit_rdy  <= 1'b0;
            r_word_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SHIFT;
                        r_bit_cnt <= '0;
                        r_bit_rdy <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_vld) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BCNT_W'(TOTAL_W - 1)) begin
                            r_state    <= UNLOAD;
                            r_word_cnt <= '0;
                            r_bit_rdy  <= 1'b0;
                            r_word_vld <= 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (word_rdy) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == WCNT_W'(NWORDS - 1)) begin
                            r_state    <= IDLE;
                            r_word_vld <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_bit_rdy  <= 1'b0;
                    r_word_vld <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bit_rdy  = r_bit_rdy;
    assign word_vld = r_word_vld;
    assign busy     = r_busy;
    assign done     = r_done;
    assign word_out = w_q[0];

endmodule
